// File: rtl/rtc_bus_master.sv
// rtc_bus_master: runs one RTC register transaction (address phase then data
// phase, three sub-phases each) on the chip's multiplexed address/data bus.
// Every output is registered. Output values are decoded from the next state,
// so the strobes change together with the state and never glitch.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   act                 RTC selected by the port decode
//   dir                 RTC register address, latched at acceptance
//   wr_en, rd_en        request strobes (write wins when both are high)
//   data_in             write data, latched at acceptance
//   data_out            last read data; holds until the next read completes
//   busy, done          transaction in progress / one-cycle completion pulse
//   cs_n, rd_n, wr_n    RTC chip select and strobes, active-low
//   ad_n                0 = address phase, 1 = data phase
//   ad_out, ad_oe       bus drive value and its output enable
//   ad_in               sampled bus value
module rtc_bus_master #(
  parameter int unsigned T_PHASE = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       act,
  input  logic [7:0] dir,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = $clog2(T_PHASE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_PHASE - 1);

  typedef enum logic [2:0] {
    IDLE,
    A_SET,
    A_STB,
    A_HLD,
    D_SET,
    D_STB,
    D_HLD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             is_wr_q, is_wr_d;

  logic [DW-1:0]    data_out_d;
  logic             busy_d, done_d;
  logic             cs_n_d, rd_n_d, wr_n_d, ad_n_d, ad_oe_d;
  logic [DW-1:0]    ad_out_d;
  logic             phase_end;

  // Next state, phase counter, request latching and read capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    data_out_d = data_out;
    phase_end  = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (act && (wr_en || rd_en)) begin
          state_d = A_SET;
          cnt_d   = '0;
          addr_d  = dir;
          wdata_d = data_in;
          is_wr_d = wr_en;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        if (phase_end) begin
          cnt_d = '0;
          case (state_q)
            A_SET:   state_d = A_STB;
            A_STB:   state_d = A_HLD;
            A_HLD:   state_d = D_SET;
            D_SET:   state_d = D_STB;
            D_STB:   state_d = D_HLD;
            D_HLD:   state_d = DONE;
            default: state_d = IDLE;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    // Read data is taken on the final cycle of the data strobe
    if (state_q == D_STB && phase_end && !is_wr_q) begin
      data_out_d = ad_in;
    end
  end

  // Bus/strobe values for the state being entered, so they register with it
  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = '0;
    busy_d   = 1'b1;
    done_d   = 1'b0;

    case (state_d)
      IDLE: begin
        busy_d = 1'b0;
      end
      A_SET, A_HLD: begin
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      A_STB: begin
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
      end
      D_SET, D_HLD: begin
        if (is_wr_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end
      end
      D_STB: begin
        cs_n_d = 1'b0;
        if (is_wr_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
          wr_n_d   = 1'b0;
        end else begin
          rd_n_d   = 1'b0;
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      is_wr_q  <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cs_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      ad_n     <= 1'b1;
      ad_oe    <= 1'b0;
      ad_out   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      is_wr_q  <= is_wr_d;
      data_out <= data_out_d;
      busy     <= busy_d;
      done     <= done_d;
      cs_n     <= cs_n_d;
      rd_n     <= rd_n_d;
      wr_n     <= wr_n_d;
      ad_n     <= ad_n_d;
      ad_oe    <= ad_oe_d;
      ad_out   <= ad_out_d;
    end
  end

endmodule

// File: tb/tb_rtc_bus_master.sv
// Bench for rtc_bus_master: two instances (T_PHASE 2 and 1) share stimulus.
// A transaction-offset model predicts every output each cycle; directed
// sequences add hand-computed literal checks.
module tb_rtc_bus_master;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       act = 1'b0;
  logic [7:0] dir = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] ad_in = '0;

  logic [7:0] data_out0, data_out1, ad_out0, ad_out1;
  logic       busy0, busy1, done0, done1, cs_n0, cs_n1, rd_n0, rd_n1;
  logic       wr_n0, wr_n1, ad_n0, ad_n1, ad_oe0, ad_oe1;

  always #5 clk = ~clk;

  rtc_bus_master #(.T_PHASE(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .act(act), .dir(dir), .wr_en(wr_en),
    .rd_en(rd_en), .data_in(data_in), .data_out(data_out0), .busy(busy0),
    .done(done0), .cs_n(cs_n0), .rd_n(rd_n0), .wr_n(wr_n0), .ad_n(ad_n0),
    .ad_out(ad_out0), .ad_oe(ad_oe0), .ad_in(ad_in)
  );

  rtc_bus_master #(.T_PHASE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .act(act), .dir(dir), .wr_en(wr_en),
    .rd_en(rd_en), .data_in(data_in), .data_out(data_out1), .busy(busy1),
    .done(done1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .ad_n(ad_n1),
    .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in)
  );

  logic [22:0] obs [2];
  assign obs[0] = {cs_n0, rd_n0, wr_n0, ad_n0, ad_oe0, ad_out0, busy0, done0, data_out0};
  assign obs[1] = {cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1, ad_out1, busy1, done1, data_out1};

  // Model: each instance is described by its offset into the current
  // transaction (0 = idle, 1..6T = bus phases, 6T+1 = done cycle).
  int         tp [2] = '{2, 1};
  int         m_off [2] = '{0, 0};
  bit         m_wr [2] = '{1'b0, 1'b0};
  logic [7:0] m_addr [2] = '{8'h00, 8'h00};
  logic [7:0] m_data [2] = '{8'h00, 8'h00};
  logic [7:0] m_dout [2] = '{8'h00, 8'h00};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_off[i]  = 0;
        m_dout[i] = 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_off[i] == 0) begin
          if (act && (wr_en || rd_en)) begin
            m_off[i]  = 1;
            m_wr[i]   = wr_en;
            m_addr[i] = dir;
            m_data[i] = data_in;
          end
        end else if (m_off[i] == 6 * tp[i] + 1) begin
          m_off[i] = 0;
        end else begin
          if (m_off[i] == 5 * tp[i] && !m_wr[i]) m_dout[i] = ad_in;
          m_off[i] = m_off[i] + 1;
        end
      end
    end
  end

  function automatic logic [22:0] exp_obs(input int t, input int off, input bit wr,
                                          input logic [7:0] a, input logic [7:0] d,
                                          input logic [7:0] dout);
    logic cs, rd, w, adn, oe, bsy, dn;
    logic [7:0] o;
    int ph;
    cs = 1'b1; rd = 1'b1; w = 1'b1; adn = 1'b1; oe = 1'b0; o = 8'h00;
    bsy = (off != 0);
    dn = 1'b0;
    if (off == 6 * t + 1) begin
      dn = 1'b1;
    end else if (off != 0) begin
      ph = (off - 1) / t;
      if (ph < 3) begin
        adn = 1'b0; oe = 1'b1; o = a;
        if (ph == 1) begin cs = 1'b0; w = 1'b0; end
      end else begin
        if (wr) begin oe = 1'b1; o = d; end
        if (ph == 4) begin
          cs = 1'b0;
          if (wr) w = 1'b0; else rd = 1'b0;
        end
      end
    end
    return {cs, rd, w, adn, oe, o, bsy, dn, dout};
  endfunction

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit hold_ad = 1'b0;

  task automatic chk(input string name, input int got, input int expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, expv, expv);
    end
  endtask

  // One cycle: wait for the falling edge, compare both instances to the model
  task automatic step();
    logic [22:0] e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      e = exp_obs(tp[i], m_off[i], m_wr[i], m_addr[i], m_data[i], m_dout[i]);
      n_tests++;
      if (obs[i] !== e) begin
        n_fail++;
        $display("FAIL cycle_cmp dut%0d cyc %0d: got %h expected %h", i, cyc, obs[i], e);
      end
    end
    if (!hold_ad) ad_in = 8'($urandom);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int a1, d7, n_astb, n_dstb, n_rd, n_wr, done_at, n_oe, dout_done, n_done, r;
    int dq [$];

    #1 reset_n = 1'b0;
    steps(3);
    chk("reset_cs_n", int'(cs_n0), 1);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_ad_n", int'(ad_n0), 1);
    reset_n = 1'b1;
    steps(2);
    act = 1'b1;

    // Write 0x59 to register 0x21
    a1 = -1; d7 = -1; n_astb = 0; n_dstb = 0; n_rd = 0; done_at = -1;
    wr_en = 1'b1; dir = 8'h21; data_in = 8'h59;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) wr_en = 1'b0;
      if (!cs_n0 && !wr_n0 && !ad_n0) n_astb++;
      if (!cs_n0 && !wr_n0 && ad_n0) n_dstb++;
      if (!rd_n0) n_rd++;
      if (done0) done_at = c;
      if (c == 1) a1 = int'(ad_out0);
      if (c == 7) d7 = int'(ad_out0);
    end
    chk("wr_addr_value", a1, 'h21);
    chk("wr_data_value", d7, 'h59);
    chk("wr_addr_strobe_cycles", n_astb, 2);
    chk("wr_data_strobe_cycles", n_dstb, 2);
    chk("wr_rd_n_low_cycles", n_rd, 0);
    chk("wr_done_offset", done_at, 13);

    // Read register 0x22 with 0x37 on the bus
    hold_ad = 1'b1; ad_in = 8'h37;
    n_oe = 0; dout_done = -1;
    rd_en = 1'b1; dir = 8'h22;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) rd_en = 1'b0;
      if (c >= 7 && c <= 12 && ad_oe0) n_oe++;
      if (done0) dout_done = int'(data_out0);
    end
    chk("rd_oe_in_data_phase", n_oe, 0);
    chk("rd_data_at_done", dout_done, 'h37);
    chk("rd_model_data", int'(m_dout[0]), 'h37);
    hold_ad = 1'b0;

    // Request with act low is ignored
    act = 1'b0; wr_en = 1'b1;
    steps(3);
    chk("gate_busy0", int'(busy0), 0);
    chk("gate_busy1", int'(busy1), 0);
    wr_en = 1'b0; act = 1'b1;
    step();

    // Second request during a transaction is ignored
    n_done = 0;
    wr_en = 1'b1; dir = 8'h30; data_in = 8'h31;
    for (int c = 1; c <= 20; c++) begin
      step();
      wr_en = 1'b0;
      rd_en = (c == 4);
      if (done0) n_done++;
    end
    chk("busy_ignore_done_count", n_done, 1);
    chk("busy_ignore_data_out", int'(data_out0), 'h37);

    // Both strobes high: write wins
    n_rd = 0; n_wr = 0;
    wr_en = 1'b1; rd_en = 1'b1; dir = 8'h40; data_in = 8'h41;
    for (int c = 1; c <= 14; c++) begin
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      if (!rd_n0) n_rd++;
      if (!wr_n0) n_wr++;
    end
    chk("both_rd_n_low_cycles", n_rd, 0);
    chk("both_wr_n_low_cycles", n_wr, 4);

    // Asynchronous reset during the data strobe
    wr_en = 1'b1; dir = 8'h50; data_in = 8'h51;
    step();
    wr_en = 1'b0;
    steps(8);
    chk("rst_pre_cs_n", int'(cs_n0), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_cs_n", int'(cs_n0), 1);
    chk("rst_async_wr_n", int'(wr_n0), 1);
    chk("rst_async_ad_oe", int'(ad_oe0), 0);
    chk("rst_async_data_out", int'(data_out0), 0);
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done0) n_done++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done0) n_done++;
    end
    chk("rst_no_done", n_done, 0);

    // Strobe held high: back-to-back writes on the T_PHASE=1 instance
    wr_en = 1'b1; dir = 8'h60; data_in = 8'h61;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (done1) dq.push_back(c);
    end
    wr_en = 1'b0;
    chk("b2b_done_count_ge2", int'(dq.size() >= 2), 1);
    if (dq.size() >= 2) chk("b2b_done_gap", dq[1] - dq[0], 8);
    steps(16);

    // Randomized traffic, checked each cycle against the model
    for (int c = 0; c < 800; c++) begin
      act     = ($urandom_range(3) != 0);
      r       = int'($urandom_range(15));
      wr_en   = (r == 0) || (r == 2);
      rd_en   = (r == 1) || (r == 2) || (r == 3);
      dir     = 8'($urandom);
      data_in = 8'($urandom);
      step();
    end
    act = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    steps(16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1);
  end

endmodule

// File: doc/rtc_bus_master.md
# rtc_bus_master

Executes one RTC register transaction per accepted request, driving the multiplexed address/data bus of the external RTC chip. It sits between the processor-side port decode and the RTC pins. The decode supplies the RTC enable and the 8-bit RTC register address (`dir`). The processor's read/write strobes start a transaction. Read data is returned on `data_out` for the processor's input mux.

## Interface
- `T_PHASE`, default 10: clock cycles per bus phase (≥1; 10 → 100 ns at 100 MHz).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `act`  in  1  RTC selected (from port decode).
- `dir`  in  8  RTC register address.
- `wr_en`  in  1  write request strobe.
- `rd_en`  in  1  read request strobe.
- `data_in`  in  8  write data.
- `data_out`  out  8  last read data; holds until the next read completes.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at transaction end.
- `cs_n`, `rd_n`, `wr_n`  out  1 each  RTC chip select, read strobe, write strobe (active-low).
- `ad_n`  out  1  address/data select: 0 = address phase, 1 = data phase.
- `ad_out`  out  8  bus drive value.
- `ad_oe`  out  1  bus output enable, used by the top-level tristate.
- `ad_in`  in  8  bus sampled value.

## Operation
- Reset values: `cs_n`=1, `rd_n`=1, `wr_n`=1, `ad_n`=1, `ad_oe`=0, `ad_out`=0, `data_out`=0, `busy`=0, `done`=0, state IDLE.
- Request acceptance:
  - Accepted only in IDLE when `act`=1 and (`wr_en` or `rd_en`).
  - `wr_en` has priority if both strobes are high.
  - `dir`, `data_in` and the direction are latched at acceptance.
  - Inputs are ignored while `busy`=1; there is no queue.
- States, each lasting exactly `T_PHASE` cycles unless noted:
  - IDLE: all strobes high, `ad_oe`=0, `busy`=0.
  - A_SET: `ad_n`=0, `ad_oe`=1, `ad_out`=latched address.
  - A_STB: as A_SET, plus `cs_n`=0 and `wr_n`=0.
  - A_HLD: strobes high, address still driven.
  - D_SET: `ad_n`=1.
    - Write: `ad_out`=latched data, `ad_oe`=1.
    - Read: `ad_oe`=0.
  - D_STB: `cs_n`=0, and `wr_n`=0 (write) or `rd_n`=0 (read).
    - Read: `ad_in` is captured into `data_out` on the last cycle of D_STB.
  - D_HLD: strobes high; write data is held; `ad_oe` follows the direction.
  - DONE: 1 cycle, `done`=1, `busy`=1. Then IDLE with `ad_oe`=0 and `ad_n`=1.
- Phase counter:
  - Width is `$clog2(T_PHASE+1)`.
  - Loads 0 on each state entry and advances the state when it reaches `T_PHASE-1`.
- `cs_n`, `rd_n` and `wr_n` are never low in the same cycle as a state in which they should be high; glitch-free.
- All outputs are registered.
- `data_out` is unchanged by writes.

## Timing
- Request high at clock edge k (state IDLE) → A_SET entered at k+1; `busy`=1 from k+1.
- Six phases occupy cycles k+1 … k+6·T_PHASE.
- `done`=1 during cycle k+6·T_PHASE+1; `busy` falls at k+6·T_PHASE+2.
- The earliest next acceptance is edge k+6·T_PHASE+2, so back-to-back period = 6·T_PHASE+2 cycles.
- Read data is valid on `data_out` in the `done` cycle.
- Reset mid-transaction: all outputs return to reset values asynchronously.
  - The partial transaction is abandoned with no `done`.
  - `data_out` clears to 0.
- Strobes held high for multiple cycles generate one transaction only if they are still high when IDLE is re-entered. The processor strobes are single-cycle, so there is no repeat.

## Test plan
- Write, `T_PHASE`=2: `act`=1, `wr_en`=1, `dir`=8'h21, `data_in`=8'h59.
  - Address 21 is driven with `ad_n`=0; `cs_n`/`wr_n` are low for 2 cycles.
  - Data 59 is driven with `ad_n`=1; `wr_n` is low for 2 cycles.
  - `done` occurs 13 cycles after acceptance; `rd_n` stays 1 throughout.
- Read, `T_PHASE`=2: `dir`=8'h22, `ad_in`=8'h37 during D_STB.
  - `ad_oe`=0 in the data phases; `data_out`=8'h37 at `done`.
- Gating: `wr_en`=1 with `act`=0 → no state change. A second request while `busy` → ignored, with exactly one `done`.
- Simultaneous `wr_en`=`rd_en`=1 → a write cycle runs and `rd_n` never goes low.
- Reset mid-operation: `reset_n` low during D_STB → `cs_n`=`wr_n`=1 and `ad_oe`=0 immediately, without waiting for a clock edge. No `done`; the next request runs normally.
- Back-to-back with `T_PHASE`=1: two writes issued at the earliest acceptance → `done` pulses 8 cycles apart.
